// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with full-scan debouncing; reports one held key as a level.
// Optional KEYPAD_STROBE_EN adds key_strobe, a one-cycle pulse when keypad_pressed rises.
module keypad_scanner #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       keypad_pressed,
  output logic [4:0] key
`ifdef KEYPAD_STROBE_EN
  ,
  output logic       key_strobe
`endif
);

  localparam int              SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [7:0]      DEB       = 8'(DEBOUNCE_SCANS);
  localparam logic [4:0]      KEY_NONE  = 5'd31;

  typedef enum logic [1:0] {IDLE, PRESS_P, HELD, REL_P} state_t;

  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'd0:  code = 5'd1;
      4'd1:  code = 5'd2;
      4'd2:  code = 5'd3;
      4'd3:  code = 5'd10;
      4'd4:  code = 5'd4;
      4'd5:  code = 5'd5;
      4'd6:  code = 5'd6;
      4'd7:  code = 5'd11;
      4'd8:  code = 5'd7;
      4'd9:  code = 5'd8;
      4'd10: code = 5'd9;
      4'd11: code = 5'd12;
      4'd12: code = 5'd14;
      4'd13: code = 5'd0;
      4'd14: code = 5'd15;
      4'd15: code = 5'd13;
    endcase
    return code;
  endfunction

  logic [3:0]        col_meta, col_sync;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        row;
  logic [1:0]        acc_cnt;
  logic [4:0]        acc_code;

  logic [3:0] hits;
  logic [2:0] hit_cnt;
  logic [1:0] hit_col;
  logic [1:0] base_cnt;
  logic [2:0] sum_cnt;
  logic [1:0] total_cnt;
  logic [4:0] scan_code;
  logic       sample, scan_done;

  always_comb begin
    hits    = ~col_sync;
    hit_cnt = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
    hit_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i]) hit_col = 2'(i);
    end
    // Contact count saturates at 2: anything beyond one closure is just MULTI.
    base_cnt  = (row == 2'd0) ? 2'd0 : acc_cnt;
    sum_cnt   = {1'b0, base_cnt} + hit_cnt;
    total_cnt = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    scan_code = (base_cnt == 2'd1) ? acc_code : key_code(row, hit_col);
    sample    = (slot == SLOT_LAST);
    scan_done = sample && (row == 2'd3);
    row_n     = ~(4'b0001 << row);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      slot     <= '0;
      row      <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 5'd0;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
      if (sample) begin
        slot     <= '0;
        row      <= row + 2'd1;
        acc_cnt  <= total_cnt;
        acc_code <= scan_code;
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

  state_t     state, state_n;
  logic [4:0] cand, cand_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic       pressed_n;
  logic [4:0] key_n;
  logic       is_key, match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cand           <= 5'd0;
      cnt            <= 8'd0;
      keypad_pressed <= 1'b0;
      key            <= KEY_NONE;
    end else begin
      state          <= state_n;
      cand           <= cand_n;
      cnt            <= cnt_n;
      keypad_pressed <= pressed_n;
      key            <= key_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    pressed_n = keypad_pressed;
    key_n     = key;
    cnt_inc   = cnt + 8'd1;
    is_key    = (total_cnt == 2'd1);
    match     = is_key && (scan_code == cand);
    if (scan_done) begin
      unique case (state)
        IDLE: if (is_key) begin
          cand_n = scan_code;
          cnt_n  = 8'd1;
          if (DEB <= 8'd1) begin
            state_n   = HELD;
            pressed_n = 1'b1;
            key_n     = scan_code;
          end else begin
            state_n = PRESS_P;
          end
        end
        PRESS_P: if (match) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= DEB) begin
            state_n   = HELD;
            pressed_n = 1'b1;
            key_n     = cand;
          end
        end else begin
          state_n = IDLE;
        end
        HELD: if (!match) begin
          cnt_n = 8'd1;
          if (DEB <= 8'd1) begin
            state_n   = IDLE;
            pressed_n = 1'b0;
            key_n     = KEY_NONE;
          end else begin
            state_n = REL_P;
          end
        end
        REL_P: if (match) begin
          state_n = HELD;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= DEB) begin
            state_n   = IDLE;
            pressed_n = 1'b0;
            key_n     = KEY_NONE;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_STROBE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_strobe <= 1'b0;
    else     key_strobe <= pressed_n && !keypad_pressed;
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, scan-level debounce model,
// directed scenarios with literal expectations and randomized key patterns.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 3;
  localparam int SCAN_CLKS = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       keypad_pressed;
  logic [4:0] key;
`ifdef KEYPAD_STROBE_EN
  logic       key_strobe;
`endif

  logic [15:0] keys = 16'h0000;
  int errors = 0;
  int checks = 0;
  bit started = 0;

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .keypad_pressed(keypad_pressed),
    .key(key)
`ifdef KEYPAD_STROBE_EN
    ,
    .key_strobe(key_strobe)
`endif
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end
  end

  int edges;
  bit m_pressed;
  int m_key;
  bit m_strobe;
  int streak_code, streak_len, miss;

  // Reference: a full scan completes every 16 clocks; debounce is tracked as streak/miss counts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges = 0; m_pressed = 0; m_key = 31; m_strobe = 0;
      streak_code = 0; streak_len = 0; miss = 0;
    end else begin
      int n, res;
      edges++;
      m_strobe = 0;
      if (edges % SCAN_CLKS == 0) begin
        n = $countones(keys);
        res = (n == 0) ? -1 : -2;
        if (n == 1) begin
          for (int i = 0; i < 16; i++) if (keys[i]) res = keymap[i];
        end
        if (!m_pressed) begin
          if (streak_len > 0) begin
            if (res == streak_code) streak_len++;
            else streak_len = 0;
          end else if (res >= 0) begin
            streak_code = res;
            streak_len  = 1;
          end
          if (streak_len >= DEB) begin
            m_pressed = 1; m_key = streak_code; m_strobe = 1;
            streak_len = 0; miss = 0;
          end
        end else begin
          if (res == m_key) miss = 0;
          else miss++;
          if (miss >= DEB) begin
            m_pressed = 0; m_key = 31; miss = 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model pressed", keypad_pressed, m_pressed);
      checkOutput("model key", key, m_key);
      checkOutput("model row_n", row_n, 4'(~(4'b0001 << ((edges / SCAN_DIV) % 4))));
`ifdef KEYPAD_STROBE_EN
      checkOutput("model strobe", key_strobe, m_strobe);
`endif
    end
  end

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks the level just before and just after the n-th scan boundary from now.
  task automatic checkAt(input string name, input int scans, input int pre, input int post, input int post_key);
    waitClks(scans * SCAN_CLKS - 1);
    checkOutput({name, " before"}, keypad_pressed, pre);
    waitClks(1);
    checkOutput({name, " pressed"}, keypad_pressed, post);
    checkOutput({name, " key"}, key, post_key);
  endtask

  logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int hold, sel, a, b;
    // Reset and row sequencing
    waitClks(3);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset row_n", row_n, 4'b1110);
    checkOutput("reset pressed", keypad_pressed, 0);
    checkOutput("reset key", key, 31);
    started = 1;
    for (int i = 1; i <= 4; i++) begin
      waitClks(SCAN_DIV);
      checkOutput("row sequence", row_n, row_seq[i % 4]);
    end

    // Hold '5' then release
    applyStimulus(16'h1 << 5);
    checkAt("press 5", DEB, 0, 1, 5);
    applyStimulus(16'h0);
    checkAt("release 5", DEB, 1, 0, 31);

    // Bounce on '#'
    applyStimulus(16'h1 << 14); waitClks(2 * SCAN_CLKS);
    applyStimulus(16'h0);       waitClks(1 * SCAN_CLKS);
    applyStimulus(16'h1 << 14); waitClks(2 * SCAN_CLKS);
    applyStimulus(16'h0);       waitClks(3 * SCAN_CLKS);
    checkOutput("bounce no press", keypad_pressed, 0);

    // '1' and '9' together, then only '1'
    applyStimulus((16'h1 << 0) | (16'h1 << 10));
    waitClks(10 * SCAN_CLKS);
    checkOutput("multi no press", keypad_pressed, 0);
    applyStimulus(16'h1 << 0);
    checkAt("press 1", DEB, 0, 1, 1);
    applyStimulus(16'h0);
    checkAt("release 1", DEB, 1, 0, 31);

    // 'A' rolled over to 'D'
    applyStimulus(16'h1 << 3);
    checkAt("press A", DEB, 0, 1, 10);
    applyStimulus(16'h1 << 15);
    checkAt("rollover release", DEB, 1, 0, 31);
    checkAt("press D", DEB, 0, 1, 13);

    // Reset while 'D' is held
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid reset pressed", keypad_pressed, 0);
    checkOutput("mid reset key", key, 31);
    checkOutput("mid reset row_n", row_n, 4'b1110);
    @(negedge clk);
    #2 rst = 1'b0;
    checkAt("re-press D", DEB, 0, 1, 13);

    // Randomized key patterns, held a few scans each
    for (int p = 0; p < 60; p++) begin
      sel = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (sel)
        0:       applyStimulus(16'h0);
        3:       applyStimulus((16'h1 << a) | (16'h1 << b));
        default: applyStimulus(16'h1 << a);
      endcase
      hold = $urandom_range(1, 6);
      waitClks(hold * SCAN_CLKS);
    end
    applyStimulus(16'h0);
    waitClks((DEB + 1) * SCAN_CLKS);
    checkOutput("final idle", keypad_pressed, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
